// File: rtl/ex_mem_reg_pkg.sv
// Shared constants for the EX/MEM boundary.
// Holds the datapath widths, the enable/zero constants and the stall-vector bit positions.
package ex_mem_reg_pkg;

    localparam int unsigned RegW       = 32;
    localparam int unsigned RegAddrW   = 5;
    localparam int unsigned DoubleRegW = 2 * RegW;
    localparam int unsigned CntW       = 2;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam logic [RegW-1:0] ZeroWord = '0;

    // Bit positions of the EX and MEM stages in the pipeline stall vector.
    localparam int unsigned StallEx  = 3;
    localparam int unsigned StallMem = 4;

endpackage

// File: rtl/ex_mem_reg_stage_reg.sv
// Width-W pipeline register with synchronous rst and flush, plus hold and bubble controls.
// Ports:
//   clk, rst (sync, active-high)
//   flush   zero the contents
//   hold    keep the contents
//   bubble  bubble slot: zero the contents, or capture d when CAPTURE_ON_BUBBLE
//   d / q   data in / registered data out
// When CAPTURE_ON_BUBBLE is set, the roles are swapped.
// Such a register captures only on bubble and clears on a normal advance.
// The loopback state uses it this way.
module stage_reg #(
    parameter int unsigned W                 = 8,
    parameter bit          CAPTURE_ON_BUBBLE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Priority: flush > hold > bubble > advance (rst handled in the flop).
    always_comb begin
        data_d = data_q;
        if (flush) begin
            data_d = '0;
        end else if (hold) begin
            data_d = data_q;
        end else if (bubble) begin
            data_d = CAPTURE_ON_BUBBLE ? d : '0;
        end else begin
            data_d = CAPTURE_ON_BUBBLE ? '0 : d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the 5-stage MIPS32 core.
// Presents the EX GPR and HI/LO write results to MEM one cycle later.
// Also loops the MADD/MSUB partial product and step count back to EX across a stall.
// Ports:
//   clk, rst (sync, active-high), flush, stall_ex, stall_mem
//   ex_*         EX results: rw, wreg, wdata, whilo, hi, lo, hilo_temp, cnt
//   mem_*        registered copies for MEM (zeroed on bubble)
//   hilo_temp_o  held partial product, back to EX
//   cnt_o        held step count, back to EX
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DW   = RegW,
    parameter int unsigned AW   = RegAddrW,
    parameter int unsigned CNTW = CntW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_ex,
    input  logic              stall_mem,
    input  logic [AW-1:0]     ex_rw,
    input  logic              ex_wreg,
    input  logic [DW-1:0]     ex_wdata,
    input  logic              ex_whilo,
    input  logic [DW-1:0]     ex_hi,
    input  logic [DW-1:0]     ex_lo,
    input  logic [2*DW-1:0]   ex_hilo_temp,
    input  logic [CNTW-1:0]   ex_cnt,
    output logic [AW-1:0]     mem_rw,
    output logic              mem_wreg,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_whilo,
    output logic [DW-1:0]     mem_hi,
    output logic [DW-1:0]     mem_lo,
    output logic [2*DW-1:0]   hilo_temp_o,
    output logic [CNTW-1:0]   cnt_o
);

    localparam int unsigned MemW  = AW + 1 + DW + 1 + DW + DW;
    localparam int unsigned LoopW = 2 * DW + CNTW;

    logic [StallMem:StallEx] stall_c;
    logic                    hold_c;
    logic                    bubble_c;
    logic [MemW-1:0]         mem_bundle_c;
    logic [MemW-1:0]         mem_bundle_q;
    logic [LoopW-1:0]        loop_bundle_c;
    logic [LoopW-1:0]        loop_bundle_q;

    // MEM stalled always holds, even when EX is not stalled.
    // Otherwise the result in the register would be dropped or duplicated.
    assign stall_c  = {stall_mem, stall_ex};
    assign hold_c   = stall_c[StallMem];
    assign bubble_c = stall_c[StallEx] & ~stall_c[StallMem];

    assign mem_bundle_c  = {ex_rw, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo};
    assign loop_bundle_c = {ex_hilo_temp, ex_cnt};

    // MEM-facing bundle: a bubble becomes a NOP.
    stage_reg #(
        .W                 (MemW),
        .CAPTURE_ON_BUBBLE (1'b0)
    ) u_mem_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .hold   (hold_c),
        .bubble (bubble_c),
        .d      (mem_bundle_c),
        .q      (mem_bundle_q)
    );

    // Loopback bundle: keeps accumulate state while EX stalls, clears on advance.
    stage_reg #(
        .W                 (LoopW),
        .CAPTURE_ON_BUBBLE (1'b1)
    ) u_loop_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .hold   (hold_c),
        .bubble (bubble_c),
        .d      (loop_bundle_c),
        .q      (loop_bundle_q)
    );

    assign {mem_rw, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo} = mem_bundle_q;
    assign {hilo_temp_o, cnt_o} = loop_bundle_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall_ex;
    logic        stall_mem;
    logic [4:0]  ex_rw;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] ex_hilo_temp;
    logic [1:0]  ex_cnt;
    logic [4:0]  mem_rw;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    ex_mem_reg dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .ex_rw        (ex_rw),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_whilo     (ex_whilo),
        .ex_hi        (ex_hi),
        .ex_lo        (ex_lo),
        .ex_hilo_temp (ex_hilo_temp),
        .ex_cnt       (ex_cnt),
        .mem_rw       (mem_rw),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .hilo_temp_o  (hilo_temp_o),
        .cnt_o        (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rw"},        64'(mem_rw),      64'd0);
        chk({tag, ".wreg"},      64'(mem_wreg),    64'd0);
        chk({tag, ".wdata"},     64'(mem_wdata),   64'd0);
        chk({tag, ".whilo"},     64'(mem_whilo),   64'd0);
        chk({tag, ".hi"},        64'(mem_hi),      64'd0);
        chk({tag, ".lo"},        64'(mem_lo),      64'd0);
        chk({tag, ".hilo_temp"}, hilo_temp_o,      64'd0);
        chk({tag, ".cnt"},       64'(cnt_o),       64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
        ex_rw = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; ex_whilo = 1'b1;
        ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222;
        ex_hilo_temp = 64'h3333_3333_4444_4444; ex_cnt = 2'd2;
        step();
        chk_all_zero("reset");

        // 1. Advance, GPR path
        rst = 1'b0;
        ex_rw = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678; ex_whilo = 1'b0;
        ex_hilo_temp = 64'h0; ex_cnt = 2'd0;
        step();
        chk("adv.rw",    64'(mem_rw),    64'd3);
        chk("adv.wreg",  64'(mem_wreg),  64'd1);
        chk("adv.wdata", 64'(mem_wdata), 64'h1234_5678);
        chk("adv.whilo", 64'(mem_whilo), 64'd0);

        // 2. Bubble with loopback
        stall_ex = 1'b1; ex_wreg = 1'b1;
        ex_hilo_temp = 64'hFFFF_FFFF_0000_0002; ex_cnt = 2'd1;
        step();
        chk("bub.wreg",      64'(mem_wreg),  64'd0);
        chk("bub.whilo",     64'(mem_whilo), 64'd0);
        chk("bub.rw",        64'(mem_rw),    64'd0);
        chk("bub.wdata",     64'(mem_wdata), 64'd0);
        chk("bub.hilo_temp", hilo_temp_o,    64'hFFFF_FFFF_0000_0002);
        chk("bub.cnt",       64'(cnt_o),     64'd1);

        // 3. Advance after the bubble; loopback inputs still nonzero but must clear
        stall_ex = 1'b0; ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
        step();
        chk("adv2.whilo",     64'(mem_whilo), 64'd1);
        chk("adv2.hi",        64'(mem_hi),    64'd1);
        chk("adv2.lo",        64'(mem_lo),    64'd2);
        chk("adv2.cnt",       64'(cnt_o),     64'd0);
        chk("adv2.hilo_temp", hilo_temp_o,    64'd0);

        // 4. Hold: 3 cycles with both stalls, inputs changing
        ex_wdata = 32'hA5A5_A5A5; ex_whilo = 1'b0;
        step();
        chk("hold.load", 64'(mem_wdata), 64'hA5A5_A5A5);
        stall_ex = 1'b1; stall_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = 32'h5000_0000 + 32'(i); ex_whilo = 1'b1; ex_cnt = 2'd3;
            ex_hilo_temp = 64'hCAFE;
            step();
            chk("hold.wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
            chk("hold.whilo", 64'(mem_whilo), 64'd0);
            chk("hold.cnt",   64'(cnt_o),     64'd0);
        end
        // Illegal stall_ex=0, stall_mem=1 must also hold
        stall_ex = 1'b0; ex_wdata = 32'h0BAD_F00D;
        step();
        chk("hold_illegal.wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
        stall_mem = 1'b0; ex_whilo = 1'b0; ex_cnt = 2'd0; ex_hilo_temp = 64'h0;
        step();
        chk("release.wdata", 64'(mem_wdata), 64'h0BAD_F00D);
        ex_wdata = 32'h7777_0001;
        step();
        chk("release.next", 64'(mem_wdata), 64'h7777_0001);

        // 5. Flush mid-MADD
        stall_ex = 1'b1; ex_cnt = 2'd1; ex_hilo_temp = 64'h0000_0001_8000_0000;
        step();
        chk("madd.cnt",       64'(cnt_o),   64'd1);
        chk("madd.hilo_temp", hilo_temp_o,  64'h0000_0001_8000_0000);
        stall_mem = 1'b1; ex_cnt = 2'd2;
        step();
        chk("madd_hold.cnt", 64'(cnt_o), 64'd1);
        flush = 1'b1;
        step();
        chk_all_zero("flush");
        flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
        ex_rw = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
        ex_whilo = 1'b1; ex_hi = 32'hABCD_0000; ex_lo = 32'h0000_ABCD;
        step();
        chk("post_flush.rw", 64'(mem_rw), 64'd31);
        chk("post_flush.hi", 64'(mem_hi), 64'hABCD_0000);

        // 6. Synchronous reset mid-stream
        rst = 1'b1;
        #2;
        chk("sync_rst.between_edges", 64'(mem_wdata), 64'hFFFF_FFFF);
        step();
        chk_all_zero("rst_edge");
        ex_wdata = 32'h1357_9BDF; stall_ex = 1'b1; ex_cnt = 2'd1; ex_hilo_temp = 64'h55;
        #3;
        chk("rst_mid.wdata", 64'(mem_wdata), 64'd0);
        step();
        chk_all_zero("rst_held");
        rst = 1'b0; stall_ex = 1'b0; ex_cnt = 2'd0;
        step();
        chk("after_rst.wdata", 64'(mem_wdata), 64'h1357_9BDF);
        chk("after_rst.lo",    64'(mem_lo),    64'h0000_ABCD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
